vga_clock_timebase: RTL

- Parametrised BCD time-of-day counter for the VGA clock display path; next generation of the clock's embedded time-keeping logic.
- Adds:
  - generic tick rate;
  - runtime 12/24 h display mode;
  - range-checked parallel load;
  - same-cycle carry resolution, so no digit ever shows an illegal value;
  - deferred-tick arbitration against the adjust buttons.
- Feeds digit/number muxing and colour-offset logic in the display top level.

---
 rtl/vga_clock_timebase.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_clock_timebase.sv
`default_nettype none
// ============================================================================
// vga_clock_timebase : BCD time-of-day counter with registered 12/24 h display.
// Optional alarm enabled by `define VGA_CLOCK_ALARM_EN.             Rev 1.0
// ============================================================================
module vga_clock_timebase #(
   parameter int CLK_HZ  = 31_500_000,
   parameter int COLOR_W = 4,
   parameter int PRESC_W = $clog2(CLK_HZ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               adj_sec,
   input  logic               adj_min,
   input  logic               adj_hrs,
   input  logic               mode_12h,
   input  logic               load,
   input  logic [21:0]        load_time,
`ifdef VGA_CLOCK_ALARM_EN
   input  logic               alarm_load,
   input  logic [12:0]        alarm_time,
   input  logic               alarm_arm,
   input  logic               alarm_ack,
   output logic               alarm_ring,
`endif
   output logic               load_err,
   output logic [1:0]         hrs_d,
   output logic [3:0]         hrs_u,
   output logic [2:0]         min_d,
   output logic [3:0]         min_u,
   output logic [2:0]         sec_d,
   output logic [3:0]         sec_u,
   output logic               pm,
   output logic               sec_pulse,
   output logic               min_wrap,
   output logic [COLOR_W-1:0] color_offset
);

   localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(CLK_HZ - 1);
   localparam logic [PRESC_W-1:0] C_PRESC_ONE = PRESC_W'(1);
   localparam logic [COLOR_W-1:0] C_COLOR_ONE = COLOR_W'(1);

   function automatic logic hrs_ok(input logic [1:0] d, input logic [3:0] u);
      return (d < 2'd2 && u <= 4'd9) || (d == 2'd2 && u <= 4'd3);
   endfunction

   function automatic logic min_ok(input logic [2:0] d, input logic [3:0] u);
      return d <= 3'd5 && u <= 4'd9;
   endfunction

   // Returns {carry, tens, units} for a 00..59 field.
   function automatic logic [7:0] inc_60(input logic [2:0] d, input logic [3:0] u);
      if (u != 4'd9)      return {1'b0, d, u + 4'd1};
      else if (d != 3'd5) return {1'b0, d + 3'd1, 4'd0};
      else                return {1'b1, 3'd0, 4'd0};
   endfunction

   function automatic logic [5:0] inc_24(input logic [1:0] d, input logic [3:0] u);
      if (d == 2'd2 && u == 4'd3) return 6'd0;
      else if (u == 4'd9)         return {d + 2'd1, 4'd0};
      else                        return {d, u + 4'd1};
   endfunction

   logic [PRESC_W-1:0] r_presc, w_presc;
   logic               r_pend, w_pend;
   logic [1:0]         r_hrs_d, w_hrs_d;
   logic [3:0]         r_hrs_u, w_hrs_u;
   logic [2:0]         r_min_d, w_min_d;
   logic [3:0]         r_min_u, w_min_u;
   logic [2:0]         r_sec_d, w_sec_d;
   logic [3:0]         r_sec_u, w_sec_u;
   logic [COLOR_W-1:0] r_color, w_color;
   logic               r_sec_ev, w_sec_ev;
   logic               r_min_ev, w_min_ev;
   logic               w_load_err;

   logic               w_tick, w_adj, w_load_ok;
   logic [7:0]         w_sec_inc, w_min_inc;
   logic [5:0]         w_hrs_inc;
   logic               unused_load_msb;

   assign w_tick    = (r_presc == C_PRESC_MAX);
   assign w_adj     = adj_sec | adj_min | adj_hrs;
   assign w_sec_inc = inc_60(r_sec_d, r_sec_u);
   assign w_min_inc = inc_60(r_min_d, r_min_u);
   assign w_hrs_inc = inc_24(r_hrs_d, r_hrs_u);
   assign w_load_ok = hrs_ok(load_time[19:18], load_time[17:14])
                   && min_ok(load_time[13:11], load_time[10:7])
                   && min_ok(load_time[6:4], load_time[3:0]);
   // The packed time is 20 bits wide; the two top bits carry nothing.
   assign unused_load_msb = ^load_time[21:20];

   always_comb begin
      w_presc    = w_tick ? '0 : r_presc + C_PRESC_ONE;
      w_pend     = r_pend;
      w_hrs_d    = r_hrs_d;
      w_hrs_u    = r_hrs_u;
      w_min_d    = r_min_d;
      w_min_u    = r_min_u;
      w_sec_d    = r_sec_d;
      w_sec_u    = r_sec_u;
      w_color    = r_color;
      w_sec_ev   = 1'b0;
      w_min_ev   = 1'b0;
      w_load_err = 1'b0;
      if (load) begin
         if (w_load_ok) begin
            {w_hrs_d, w_hrs_u, w_min_d, w_min_u, w_sec_d, w_sec_u} = load_time[19:0];
            w_presc = '0;
            w_pend  = 1'b0;
         end else begin
            w_load_err = 1'b1;
         end
      end else if (w_adj) begin
         // Adjusts wrap in place; a coinciding tick is deferred one cycle.
         if (adj_sec) {w_sec_d, w_sec_u} = w_sec_inc[6:0];
         if (adj_min) begin
            {w_min_d, w_min_u} = w_min_inc[6:0];
            w_color            = r_color + C_COLOR_ONE;
         end
         if (adj_hrs) {w_hrs_d, w_hrs_u} = w_hrs_inc;
         if (w_tick)  w_pend = 1'b1;
      end else if (w_tick || r_pend) begin
         w_pend             = 1'b0;
         w_sec_ev           = 1'b1;
         {w_sec_d, w_sec_u} = w_sec_inc[6:0];
         if (w_sec_inc[7]) begin
            w_min_ev           = 1'b1;
            w_color            = r_color + C_COLOR_ONE;
            {w_min_d, w_min_u} = w_min_inc[6:0];
            if (w_min_inc[7]) {w_hrs_d, w_hrs_u} = w_hrs_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc  <= '0;
         r_pend   <= 1'b0;
         r_hrs_d  <= '0;
         r_hrs_u  <= '0;
         r_min_d  <= '0;
         r_min_u  <= '0;
         r_sec_d  <= '0;
         r_sec_u  <= '0;
         r_color  <= '0;
         r_sec_ev <= 1'b0;
         r_min_ev <= 1'b0;
         load_err <= 1'b0;
      end else begin
         r_presc  <= w_presc;
         r_pend   <= w_pend;
         r_hrs_d  <= w_hrs_d;
         r_hrs_u  <= w_hrs_u;
         r_min_d  <= w_min_d;
         r_min_u  <= w_min_u;
         r_sec_d  <= w_sec_d;
         r_sec_u  <= w_sec_u;
         r_color  <= w_color;
         r_sec_ev <= w_sec_ev;
         r_min_ev <= w_min_ev;
         load_err <= w_load_err;
      end
   end

   logic [4:0] w_hour, w_h12;
   logic [1:0] w_disp_hd;
   logic [3:0] w_disp_hu;

   assign w_hour = 5'(r_hrs_d) * 5'd10 + 5'(r_hrs_u);

   always_comb begin
      w_h12 = w_hour;
      if (w_hour == 5'd0)      w_h12 = 5'd12;
      else if (w_hour > 5'd12) w_h12 = w_hour - 5'd12;
      w_disp_hd = r_hrs_d;
      w_disp_hu = r_hrs_u;
      if (mode_12h) begin
         if (w_h12 >= 5'd10) begin
            w_disp_hd = 2'd1;
            w_disp_hu = 4'(w_h12 - 5'd10);
         end else begin
            w_disp_hd = 2'd0;
            w_disp_hu = w_h12[3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hrs_d        <= '0;
         hrs_u        <= '0;
         min_d        <= '0;
         min_u        <= '0;
         sec_d        <= '0;
         sec_u        <= '0;
         pm           <= 1'b0;
         sec_pulse    <= 1'b0;
         min_wrap     <= 1'b0;
         color_offset <= '0;
      end else begin
         hrs_d        <= w_disp_hd;
         hrs_u        <= w_disp_hu;
         min_d        <= r_min_d;
         min_u        <= r_min_u;
         sec_d        <= r_sec_d;
         sec_u        <= r_sec_u;
         pm           <= (w_hour >= 5'd12);
         sec_pulse    <= r_sec_ev;
         min_wrap     <= r_min_ev;
         color_offset <= r_color;
      end
   end

`ifdef VGA_CLOCK_ALARM_EN
   logic [1:0] r_al_hrs_d;
   logic [3:0] r_al_hrs_u;
   logic [2:0] r_al_min_d;
   logic [3:0] r_al_min_u;
   logic       r_hit, w_hit;

   // w_sec_ev is only raised by natural ticks, so adjust/load never ring.
   assign w_hit = w_sec_ev && w_sec_inc[7] && alarm_arm
               && {w_hrs_d, w_hrs_u, w_min_d, w_min_u}
                  == {r_al_hrs_d, r_al_hrs_u, r_al_min_d, r_al_min_u};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_al_hrs_d <= '0;
         r_al_hrs_u <= '0;
         r_al_min_d <= '0;
         r_al_min_u <= '0;
         r_hit      <= 1'b0;
         alarm_ring <= 1'b0;
      end else begin
         if (alarm_load && hrs_ok(alarm_time[12:11], alarm_time[10:7])
                        && min_ok(alarm_time[6:4], alarm_time[3:0]))
            {r_al_hrs_d, r_al_hrs_u, r_al_min_d, r_al_min_u} <= alarm_time;
         r_hit <= w_hit;
         if (!alarm_arm || alarm_ack) alarm_ring <= 1'b0;
         else if (r_hit)              alarm_ring <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire
